// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between N_REQ byte clients, round-robin per message
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int HOLD_TIMEOUT = 1024,
  parameter int TO_W = 16
) (
  input  logic               iCLK_50,
  input  logic               iRST_N,
  input  logic [N_REQ-1:0]   iREQ,
  input  logic [N_REQ-1:0]   iLAST,
  input  logic [8*N_REQ-1:0] iDATA,
  output logic [N_REQ-1:0]   oACK,
  output logic [N_REQ-1:0]   oGRANT,
  output logic               oTX_START,
  output logic [7:0]         oTX_DATA,
  input  logic               iTX_DONE,
  output logic               oBUSY
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, idx_q, idx_d, sel, who;
  logic last_q, last_d, take;
  logic [7:0] data_q, data_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  // descending scan so the nearest requester after rr_q is the last writer
  always_comb begin
    sel = rr_q;
    for (int i = N_REQ; i >= 1; i--)
      if (iREQ[IW'((int'(rr_q) + i) % N_REQ)]) sel = IW'((int'(rr_q) + i) % N_REQ);
  end
  assign who  = state_q == IDLE ? sel : idx_q;
  assign take = iRST_N && ((state_q == IDLE && |iREQ) || (state_q == HOLD && iREQ[idx_q]));
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      rr_q    <= IW'(N_REQ - 1);
      idx_q   <= '0;
      last_q  <= 1'b0;
      data_q  <= 8'h00;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end
  // a pending request in HOLD takes priority over timeout expiry
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    last_d  = last_q;
    data_d  = data_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    if (take) begin
      idx_d   = who;
      last_d  = iLAST[who];
      data_d  = iDATA[8*who +: 8];
      grant_d = N_REQ'(1) << who;
      state_d = START;
    end else begin
      case (state_q)
        START: state_d = WAIT;
        WAIT: if (iTX_DONE) begin
          if (last_q) begin
            grant_d = '0;
            rr_d    = idx_q;
            state_d = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = HOLD;
          end
        end
        HOLD: if (cnt_q == TO_W'(HOLD_TIMEOUT - 1)) begin
          grant_d = '0;
          rr_d    = idx_q;
          state_d = IDLE;
        end else cnt_d = cnt_q + 1'b1;
        default: ;
      endcase
    end
  end
  always_comb begin
    oACK      = take ? N_REQ'(1) << who : '0;
    oGRANT    = grant_q;
    oTX_START = state_q == START;
    oTX_DATA  = data_q;
    oBUSY     = state_q != IDLE;
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench with client and uart_tx models
module tb_uart_tx_arbiter;
  localparam int N = 4, HT = 1024, DLY = 6;
  logic clk = 0, rst_n = 0;
  logic [N-1:0] req = '0, last = '0, taken = '0;
  logic [8*N-1:0] data = '0;
  logic [N-1:0] ack, grant;
  logic tx_start, busy, tx_done, uart_done = 0, man_done = 0;
  logic [7:0] tx_data, cur = 0;
  int checks = 0, errors = 0, cyc = 0, ucnt = 0, done_cyc = -1;
  bit gap_en = 0;
  logic [8:0] pend [N][$];
  logic [11:0] exp_q [$];
  assign tx_done = uart_done | man_done;
  always #10 clk = ~clk;
  uart_tx_arbiter #(.N_REQ(N), .HOLD_TIMEOUT(HT), .TO_W(16)) dut (
    .iCLK_50(clk), .iRST_N(rst_n), .iREQ(req), .iLAST(last), .iDATA(data),
    .oACK(ack), .oGRANT(grant), .oTX_START(tx_start), .oTX_DATA(tx_data),
    .iTX_DONE(tx_done), .oBUSY(busy));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic send(input int c, input bit l, input logic [7:0] d);
    pend[c].push_back({l, d});
  endtask
  task automatic xp(input int c, input logic [7:0] d);
    exp_q.push_back({4'(c), d});
  endtask
  function automatic bit pend_empty();
    int s = 0;
    for (int k = 0; k < N; k++) s += pend[k].size();
    return s == 0;
  endfunction
  // one clock: check outputs, model uart_tx, then drive the clients
  task automatic step();
    logic [11:0] e;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      chk("ack_onehot0", 32'($onehot0(ack)), 1);
      chk("grant_onehot0", 32'($onehot0(grant)), 1);
      if (tx_start) begin
        chk("start_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("start_grant", 32'(grant), 32'(1) << e[11:8]);
          chk("start_data", 32'(tx_data), 32'(e[7:0]));
          cur = e[7:0];
          if (gap_en && done_cyc >= 0) chk("done_to_start", cyc - done_cyc, 2);
        end
      end else if (ucnt != 0) chk("data_hold", 32'(tx_data), 32'(cur));
    end
    uart_done = 0;
    if (!rst_n) begin
      ucnt = 0;
      done_cyc = -1;
    end else if (tx_start) ucnt = DLY;
    else if (ucnt != 0) begin
      ucnt--;
      if (ucnt == 0) begin
        uart_done = 1;
        done_cyc = cyc;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (taken[k]) begin
        req[k] = 0;
        taken[k] = 0;
      end else if (!req[k] && pend[k].size() != 0) begin
        {last[k], data[8*k +: 8]} = pend[k].pop_front();
        req[k] = 1;
      end
    end
    #1;
    taken = req & ack;
  endtask
  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int n = 0; n < 5000 && !ok; n++) begin
      step();
      ok = !busy && req == '0 && exp_q.size() == 0 && pend_empty();
    end
    chk(tag, 32'(ok), 1);
  endtask
  task automatic wait_done(input string tag);
    bit ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      step();
      ok = uart_done;
    end
    chk(tag, 32'(ok), 1);
  endtask
  task automatic wait_start(input string tag);
    bit ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      step();
      ok = tx_start;
    end
    chk(tag, 32'(ok), 1);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_start"}, 32'(tx_start), 0);
    chk({tag, "_data"}, 32'(tx_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask
  initial begin
    // all clients request through reset; grants rotate 0,1,2,3 then 0 again
    for (int k = 0; k < N; k++) send(k, 1, 8'h10 + 8'(k));
    send(0, 1, 8'h14);
    for (int k = 0; k < N; k++) xp(k, 8'h10 + 8'(k));
    xp(0, 8'h14);
    repeat (3) step();
    chk_reset("t1_rst");
    @(posedge clk);
    #1 rst_n = 1;
    gap_en = 1;
    wait_idle("t1_idle");
    gap_en = 0;
    // single byte: ack in the capture cycle, start one clock later
    send(2, 1, 8'hA5);
    xp(2, 8'hA5);
    step();
    chk("t2_ack", 32'(ack), 32'h4);
    chk("t2_nostart", 32'(tx_start), 0);
    step();
    chk("t2_start", 32'(tx_start), 1);
    chk("t2_data", 32'(tx_data), 32'hA5);
    chk("t2_grant", 32'(grant), 32'h4);
    chk("t2_ack_clear", 32'(ack), 0);
    wait_idle("t2_idle");
    // stray done in IDLE
    man_done = 1;
    step();
    man_done = 0;
    chk("t6_idle_busy", 32'(busy), 0);
    step();
    chk("t6_idle_start", 32'(tx_start), 0);
    // locked three-byte message; client 0 must wait for its end
    gap_en = 1;
    done_cyc = -1;
    send(1, 0, 8'h11);
    send(1, 0, 8'h22);
    send(1, 1, 8'h33);
    xp(1, 8'h11);
    xp(1, 8'h22);
    xp(1, 8'h33);
    repeat (2) step();
    send(0, 1, 8'hAA);
    xp(0, 8'hAA);
    wait_idle("t3_idle");
    gap_en = 0;
    // hold timeout with a stray done in HOLD, then pending client 0 served
    send(3, 0, 8'h55);
    send(0, 1, 8'hC3);
    xp(3, 8'h55);
    xp(0, 8'hC3);
    wait_done("t4_done");
    for (int i = 1; i <= HT; i++) begin
      man_done = (i == 5);
      step();
    end
    man_done = 0;
    chk("t4_hold_busy", 32'(busy), 1);
    chk("t4_hold_grant", 32'(grant), 32'h8);
    step();
    chk("t4_rel_busy", 32'(busy), 0);
    chk("t4_rel_grant", 32'(grant), 0);
    chk("t4_rel_ack", 32'(ack), 32'h1);
    wait_idle("t4_idle");
    // asynchronous reset in WAIT; round robin restarts from client 0
    send(1, 1, 8'h77);
    xp(1, 8'h77);
    wait_start("t5_start");
    repeat (2) step();
    rst_n = 0;
    #1;
    chk_reset("t5_rst");
    repeat (2) step();
    @(posedge clk);
    #1 rst_n = 1;
    send(2, 1, 8'h99);
    send(0, 1, 8'h5A);
    xp(0, 8'h5A);
    xp(2, 8'h99);
    wait_idle("t5_idle");
    chk("final_queue", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
